// File: rtl/dram_mon.sv
// DRAM chip-select protocol checker: flags dual-rank selects and early rank switches per channel.
// Optional error counter output err_cnt is enabled by defining DRAM_MON_ERRCNT_EN.
module dram_mon #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_GAP = 6,
    parameter int unsigned GAP_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [NUM_CH-1:0]     cmd_vld,
    input  logic [2*NUM_CH-1:0]   cs_l,
    output logic [NUM_CH-1:0]     err_both,
    output logic [NUM_CH-1:0]     err_early,
`ifdef DRAM_MON_ERRCNT_EN
    output logic [15:0]           err_cnt,
`endif
    output logic                  err_any
);

    localparam logic [GAP_W-1:0] MIN_GAP_W = GAP_W'(MIN_GAP);

    logic [NUM_CH-1:0][1:0]            act_q, act_d;
    logic [NUM_CH-1:0][1:0][GAP_W-1:0] gap_q, gap_d;
    logic [NUM_CH-1:0][1:0]            rld;
    logic [NUM_CH-1:0]                 both_d, early_d;
    logic [NUM_CH-1:0]                 both_q, early_q;
    logic                              any_q, any_d;

    // Rank 0 is resolved before rank 1, so a dual select ends with rank 1 active
    // and rank 1 sees the freshly reloaded rank 0 as an early switch.
    always_comb begin
        act_d   = act_q;
        gap_d   = gap_q;
        rld     = '0;
        both_d  = '0;
        early_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cmd_vld[c]) begin
                both_d[c] = !cs_l[2*c] && !cs_l[2*c+1];
                if (!cs_l[2*c]) begin
                    if (act_q[c][1] && (gap_q[c][1] < MIN_GAP_W))
                        early_d[c] = 1'b1;
                    act_d[c][0] = 1'b1;
                    act_d[c][1] = 1'b0;
                    rld[c][0]   = 1'b1;
                end
                if (!cs_l[2*c+1]) begin
                    if (act_d[c][0] && (rld[c][0] || (gap_q[c][0] < MIN_GAP_W)))
                        early_d[c] = 1'b1;
                    act_d[c][1] = 1'b1;
                    act_d[c][0] = 1'b0;
                    rld[c][1]   = 1'b1;
                end
            end
            for (int unsigned r = 0; r < 2; r++) begin
                if (rld[c][r])
                    gap_d[c][r] = GAP_W'(1);
                else if (act_d[c][r])
                    gap_d[c][r] = gap_q[c][r] + GAP_W'(1);
                if (act_d[c][r] && (gap_d[c][r] == MIN_GAP_W))
                    act_d[c][r] = 1'b0;
            end
        end
        any_d = any_q | (|both_d) | (|early_d);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            act_q   <= '0;
            gap_q   <= '0;
            both_q  <= '0;
            early_q <= '0;
            any_q   <= 1'b0;
        end else begin
            act_q   <= act_d;
            gap_q   <= gap_d;
            both_q  <= both_d;
            early_q <= early_d;
            any_q   <= any_d;
        end
    end

    assign err_both  = both_q;
    assign err_early = early_q;
    assign err_any   = any_q;

`ifdef DRAM_MON_ERRCNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    // Counts every pulse bit of both error kinds, so a dual select adds two.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 17'($countones(both_d)) + 17'($countones(early_d));
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dram_mon.sv
// Randomized self-checking bench for dram_mon against a select-timestamp reference model.
module tb_dram_mon;
    localparam int NUM_CH  = 4;
    localparam int MIN_GAP = 6;

    logic                clk;
    logic                rst_l;
    logic [NUM_CH-1:0]   cmd_vld;
    logic [2*NUM_CH-1:0] cs_l;
    logic [NUM_CH-1:0]   err_both;
    logic [NUM_CH-1:0]   err_early;
    logic                err_any;
`ifdef DRAM_MON_ERRCNT_EN
    logic [15:0]         err_cnt;
`endif

    dram_mon #(.NUM_CH(NUM_CH), .MIN_GAP(MIN_GAP), .GAP_W(3)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .cmd_vld   (cmd_vld),
        .cs_l      (cs_l),
        .err_both  (err_both),
        .err_early (err_early),
`ifdef DRAM_MON_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .err_any   (err_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: per channel, which rank was selected last and on which cycle.
    int                cyc;
    int                last_rank [NUM_CH];
    int                last_t    [NUM_CH];
    logic [NUM_CH-1:0] exp_both;
    logic [NUM_CH-1:0] exp_early;
    logic              exp_any;
    int                exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            last_rank[c] = -1;
            last_t[c]    = 0;
        end
        exp_both  = '0;
        exp_early = '0;
        exp_any   = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] v, input logic [2*NUM_CH-1:0] cs);
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            logic s0, s1, b, e;
            s0 = !cs[2*c];
            s1 = !cs[2*c+1];
            b  = 1'b0;
            e  = 1'b0;
            if (v[c]) begin
                b = s0 & s1;
                if (s0) begin
                    if (last_rank[c] == 1 && (cyc - last_t[c]) < MIN_GAP) e = 1'b1;
                    last_rank[c] = 0;
                    last_t[c]    = cyc;
                end
                if (s1) begin
                    if (last_rank[c] == 0 && (cyc - last_t[c]) < MIN_GAP) e = 1'b1;
                    last_rank[c] = 1;
                    last_t[c]    = cyc;
                end
            end
            exp_both[c]  = b;
            exp_early[c] = e;
            exp_cnt      = exp_cnt + int'(b) + int'(e);
        end
        if (exp_cnt > 65535) exp_cnt = 65535;
        exp_any = exp_any | (|exp_both) | (|exp_early);
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_both"},  32'(err_both),  32'(exp_both));
        check({tag, "_early"}, 32'(err_early), 32'(exp_early));
        check({tag, "_any"},   32'(err_any),   32'(exp_any));
`ifdef DRAM_MON_ERRCNT_EN
        check({tag, "_cnt"},   32'(err_cnt),   32'(exp_cnt));
`endif
    endtask

    task automatic step(input logic [NUM_CH-1:0] v, input logic [2*NUM_CH-1:0] cs);
        cmd_vld = v;
        cs_l    = cs;
        @(posedge clk);
        model_edge(v, cs);
        #1;
        compare_outputs("step");
    endtask

    task automatic pulse_reset();
        rst_l = 1'b0;
        #2;
        model_reset();
        compare_outputs("rst");
        rst_l = 1'b1;
    endtask

    initial begin
        cyc     = 0;
        rst_l   = 1'b0;
        cmd_vld = '0;
        cs_l    = '1;
        model_reset();
        #12;
        check("reset_both",  32'(err_both),  32'h0);
        check("reset_early", 32'(err_early), 32'h0);
        check("reset_any",   32'(err_any),   32'h0);
        rst_l = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) step(NUM_CH'($urandom), '1);
        check("idle_any", 32'(err_any), 32'h0);

        // Ch0: rank1 three cycles after rank0 is early.
        step(4'b0001, 8'hFE);
        step('0, '1);
        step('0, '1);
        step(4'b0001, 8'hFD);
        check("ch0_gap3_early", 32'(err_early[0]), 32'h1);
        check("ch0_gap3_any",   32'(err_any),      32'h1);
        step('0, '1);
        check("ch0_pulse_end",  32'(err_early[0]), 32'h0);
        for (int i = 0; i < 8; i++) step('0, '1);

        // Ch1: gap 5 is early, gap 6 is legal.
        step(4'b0010, 8'hFB);
        for (int i = 0; i < 4; i++) step('0, '1);
        step(4'b0010, 8'hF7);
        check("ch1_gap5_early", 32'(err_early[1]), 32'h1);
        for (int i = 0; i < 8; i++) step('0, '1);
        step(4'b0010, 8'hFB);
        for (int i = 0; i < 5; i++) step('0, '1);
        step(4'b0010, 8'hF7);
        check("ch1_gap6_ok", 32'(err_early[1]), 32'h0);
        for (int i = 0; i < 8; i++) step('0, '1);

        // Ch2: dual select, then rank0 two cycles later.
        step(4'b0100, 8'hCF);
        check("ch2_both",  32'(err_both[2]),  32'h1);
        check("ch2_early", 32'(err_early[2]), 32'h1);
        step('0, '1);
        step(4'b0100, 8'hEF);
        check("ch2_r0_after_both", 32'(err_early[2]), 32'h1);
        check("ch2_r0_no_both",    32'(err_both[2]),  32'h0);
        for (int i = 0; i < 8; i++) step('0, '1);

        // Ch3: repeated rank0 is legal; unstrobed selects are ignored.
        for (int i = 0; i < 6; i++) step(4'b1000, 8'hBF);
        check("ch3_repeat_ok", 32'(err_early[3]), 32'h0);
        step('0, 8'h3F);
        check("ch3_no_vld", 32'(err_both[3]), 32'h0);
        for (int i = 0; i < 8; i++) step('0, '1);

        // Reset inside the window forgets the earlier select.
        step(4'b0001, 8'hFE);
        step('0, '1);
        pulse_reset();
        step('0, '1);
        step(4'b0001, 8'hFD);
        check("rst_window_ok", 32'(err_early[0]), 32'h0);
        check("rst_window_any", 32'(err_any), 32'h0);
        for (int i = 0; i < 8; i++) step('0, '1);

        // All four channels dual-select together.
        step('1, 8'h00);
        check("all_both",  32'(err_both),  32'hF);
        check("all_early", 32'(err_early), 32'hF);
`ifdef DRAM_MON_ERRCNT_EN
        check("all_cnt8", 32'(err_cnt), 32'd8);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [2*NUM_CH-1:0] cs;
            for (int b = 0; b < 2*NUM_CH; b++) cs[b] = ($urandom_range(0, 9) >= 3);
            step(NUM_CH'($urandom), cs);
            if ($urandom_range(0, 79) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
